// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and payload type for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

    localparam int unsigned WORD        = 32;
    localparam int unsigned REG_LOG     = 5;
    localparam int unsigned NUM_REGS    = 32'(1) << REG_LOG;
    localparam int unsigned NUM_REQ_DEF = 3;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LSU = 1;
    localparam int unsigned REQ_MDU = 2;

    typedef struct packed {
        logic [REG_LOG-1:0] rd;
        logic [WORD-1:0]    data;
    } wb_req_t;

    // Width of a counter that must reach `limit` without wrapping.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_age_picker.sv
// Fixed-priority picker with per-requester wait counters; a requester that
// has waited STARVE_LIMIT cycles outranks every non-starved one.
module rf_wb_arbiter_rr_age_picker
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = NUM_REQ_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant
);

    localparam int unsigned CW = cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0]      wait_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] starved;
    logic [NUM_REQ-1:0] pool;

    // Starved requesters form the candidate pool when any exist; lowest index wins.
    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starved[i] = valid[i] && (wait_cnt[i] >= LIMIT);
        end
        pool  = (|starved) ? starved : valid;
        grant = rst ? '0 : (pool & (~pool + NUM_REQ'(1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!valid[i] || grant[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] < LIMIT) begin
                    wait_cnt[i] <= wait_cnt[i] + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with a busy scoreboard for long-latency
// destinations; winning write is registered and presented one cycle later.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = NUM_REQ_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*REG_LOG-1:0] req_rd,
    input  logic [NUM_REQ*WORD-1:0]    req_data,
    input  logic                       sb_set,
    input  logic [REG_LOG-1:0]         sb_rd,
    input  logic                       flush,
    input  logic [REG_LOG-1:0]         rs0,
    input  logic [REG_LOG-1:0]         rs1,
    input  logic [REG_LOG-1:0]         rs2,
    output logic                       busy0,
    output logic                       busy1,
    output logic                       busy2,
    output logic                       RFWrite,
    output logic [REG_LOG-1:0]         rd,
    output logic [WORD-1:0]            rd_WriteData
);

    logic [NUM_REQ-1:0]  grant;
    logic                gnt_any;
    wb_req_t             sel;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    rf_wb_arbiter_rr_age_picker #(
        .NUM_REQ      (NUM_REQ),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_picker (
        .clk   (clk),
        .rst   (rst),
        .valid (req_valid),
        .grant (grant)
    );

    assign req_ready = grant;
    assign gnt_any   = |grant;

    // One-hot grant selects the winning slice.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel.rd   = req_rd[i*REG_LOG +: REG_LOG];
                sel.data = req_data[i*WORD +: WORD];
            end
        end
    end

    // Writes to r0 complete the handshake but never assert the write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RFWrite      <= 1'b0;
            rd           <= '0;
            rd_WriteData <= '0;
        end else begin
            RFWrite <= gnt_any && (sel.rd != '0);
            if (gnt_any) begin
                rd           <= sel.rd;
                rd_WriteData <= sel.data;
            end
        end
    end

    // Later assignments win: a new issue to a register outranks its commit or a flush.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end
        if (gnt_any) begin
            busy_nxt[sel.rd] = 1'b0;
        end
        if (sb_set && (sb_rd != '0)) begin
            busy_nxt[sb_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy0 = busy[rs0];
    assign busy1 = busy[rs1];
    assign busy2 = busy[rs2];

endmodule
